// File: rtl/move_queue.sv
// move_queue: unpacks a move bundle into 4-bit moves, queues them and hands
// them one at a time to the stepper driver via a start/done handshake.
// Optional build macro MOVE_CANCEL_EN removes adjacent inverse moves at ingest.
module move_queue #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned SLOTS = 50
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [4*SLOTS-1:0] moves,
    input  logic               run,
    input  logic               move_done,
    output logic [3:0]         next_move,
    output logic               move_start,
    output logic               busy,
    output logic               seq_done,
    output logic [7:0]         num_moves,
    output logic [7:0]         curr_step,
    output logic [7:0]         cancelled,
    output logic               overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned BUS_W  = 4 * SLOTS;
    localparam int unsigned SLOT_W = $clog2(SLOTS + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               running;
    logic               issue_c;
    logic               finish_c;

    logic [BUS_W-1:0]   shreg;
    logic [SLOT_W-1:0]  slot_left;
    logic [3:0]         code_c;
    logic               valid_c;
    logic               cancel_c;
    logic               push_c;
    logic               drop_c;
    logic               full_c;

    logic [3:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Slot currently being examined is always the top nibble of the shifter
    assign code_c  = shreg[BUS_W-1 -: 4];
    assign valid_c = busy && (code_c >= 4'd2) && (code_c <= 4'd13);
    assign full_c  = (num_moves == 8'(DEPTH));

`ifdef MOVE_CANCEL_EN
    logic [3:0] tail_c;

    // Inverse of the tail cancels it, unless the tail is leaving for issue now
    assign tail_c   = mem[wr_ptr - PTR_W'(1)];
    assign cancel_c = valid_c && (num_moves != 8'd0)
                      && (code_c == (tail_c ^ 4'd1))
                      && !(issue_c && (num_moves == 8'd1));
`else
    assign cancel_c = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full queue still accepts
    assign push_c = valid_c && !cancel_c && (!full_c || issue_c);
    assign drop_c = valid_c && !cancel_c && full_c && !issue_c;

    // Dispatch state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dispatch next-state and issue/finish decisions
    always_comb begin
        state_next = state;
        issue_c    = 1'b0;
        finish_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (running || run) begin
                    if (num_moves != 8'd0) begin
                        issue_c    = 1'b1;
                        state_next = S_WAIT;
                    end else if (!busy) begin
                        finish_c = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (move_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Registered handshake outputs, run flag and issue counter
    always_ff @(posedge clock) begin
        if (reset) begin
            next_move  <= 4'd0;
            move_start <= 1'b0;
            seq_done   <= 1'b0;
            running    <= 1'b0;
            curr_step  <= 8'd0;
            rd_ptr     <= '0;
        end else begin
            move_start <= issue_c;
            seq_done   <= finish_c;
            if (finish_c) begin
                running <= 1'b0;
            end else if (run) begin
                running <= 1'b1;
            end
            if (issue_c) begin
                next_move <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
                if (curr_step != 8'hFF) begin
                    curr_step <= curr_step + 8'd1;
                end
            end
        end
    end

    // Bundle capture and one-slot-per-cycle unpacking, highest slot first
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg     <= '0;
            slot_left <= '0;
            busy      <= 1'b0;
        end else if (busy) begin
            shreg <= {shreg[BUS_W-5:0], 4'd0};
            if (slot_left == '0) begin
                busy <= 1'b0;
            end else begin
                slot_left <= slot_left - SLOT_W'(1);
            end
        end else if (load) begin
            shreg     <= moves;
            slot_left <= SLOT_W'(SLOTS - 1);
            busy      <= 1'b1;
        end
    end

    // Queue tail pointer, occupancy and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            num_moves <= 8'd0;
            overflow  <= 1'b0;
        end else begin
            if (cancel_c) begin
                wr_ptr <= wr_ptr - PTR_W'(1);
            end else if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            num_moves <= num_moves + 8'(push_c) - 8'(issue_c) - 8'(cancel_c);
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Queue storage; contents are meaningless outside the pointer window
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr] <= code_c;
        end
    end

`ifdef MOVE_CANCEL_EN
    // Saturating count of moves removed by cancellation (two per event)
    always_ff @(posedge clock) begin
        if (reset) begin
            cancelled <= 8'd0;
        end else if (cancel_c) begin
            cancelled <= (cancelled >= 8'd254) ? 8'hFF : cancelled + 8'd2;
        end
    end
`else
    assign cancelled = 8'd0;
`endif

endmodule
